sram_arbiter_2p: RTL and testbench
==================================

SRAM_ARBITER_2P -- requirements
Module: sram_arbiter_2p

Interface
REQ-001 Parameter TIMEOUT_CYC, default 15, SHALL set the maximum WAIT cycles before an error response.
REQ-002 i_clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 i_reset  in  1  SHALL be an asynchronous, active-low reset.
REQ-004 i_mN_ADDR  in  18  SHALL be the requester N halfword address (N = 0, 1 for all mN ports).
REQ-005 i_mN_WDATA  in  32  SHALL be the requester N write data.
REQ-006 i_mN_BMASK  in  4  SHALL be the requester N byte mask.
REQ-007 i_mN_WREN / i_mN_RDEN  in  1 each  SHALL be requester N level-held request strobes.
REQ-008 o_mN_RDATA  out  32  SHALL be the requester N read data, valid only while o_mN_ACK=1.
REQ-009 o_mN_ACK  out  1  SHALL be a one-cycle completion pulse to requester N.
REQ-010 o_mN_ERR  out  1  SHALL qualify o_mN_ACK as an error completion.
REQ-011 o_ADDR/o_WDATA/o_BMASK/o_WREN/o_RDEN  out  18/32/4/1/1  SHALL drive the downstream 32-bit SRAM controller.
REQ-012 i_RDATA  in  32 and i_ACK  in  1  SHALL be the downstream read data and completion pulse.
REQ-013 o_BUSY  out  1  SHALL be 1 in every state except IDLE.

Function
REQ-014 A request from N SHALL be pending when i_mN_WREN|i_mN_RDEN=1; requester holds all inputs stable until its o_mN_ACK pulse.
REQ-015 FSM states SHALL be IDLE, ISSUE, WAIT, ERRRSP.
REQ-016 IDLE: no pending request -> stay; else grant per REQ-017, register the granted request (addr, wdata, bmask, wren, rden, grant id) and go to ISSUE.
REQ-017 Both ports pending SHALL grant the port not granted last (round-robin); single pending port SHALL be granted regardless of history.
REQ-018 Granted request with WREN=RDEN=1 SHALL go to ERRRSP instead of ISSUE and SHALL not drive the downstream port.
REQ-019 ISSUE SHALL drive registered o_WREN/o_RDEN high for exactly one cycle, then go to WAIT.
REQ-020 o_WREN and o_RDEN SHALL be 0 in every state other than ISSUE (prevents downstream re-launch in its ack cycle).
REQ-021 o_ADDR/o_WDATA/o_BMASK SHALL hold the registered request values from ISSUE through the end of WAIT.
REQ-022 WAIT with i_ACK=1 SHALL pulse o_mG_ACK (G = granted port) combinationally in that cycle, with o_mG_RDATA = i_RDATA and o_mG_ERR = 0, then go to IDLE.
REQ-023 WAIT SHALL count cycles from 0; when the count reaches TIMEOUT_CYC without i_ACK, go to ERRRSP.
REQ-024 ERRRSP SHALL pulse o_mG_ACK=1, o_mG_ERR=1, o_mG_RDATA=0 for one cycle, then go to IDLE.
REQ-025 The non-granted port SHALL see ACK=0, ERR=0, RDATA=0 at all times.
REQ-026 i_ACK outside WAIT SHALL be ignored.
REQ-027 Latency from request sampled in IDLE: write ack in cycle +3, read ack in cycle +4 (ISSUE +1, downstream 2/3 cycles).
REQ-028 A requester may present a new request in the cycle after its ack; it is arbitrated in that IDLE cycle.
REQ-029 The last-grant flag SHALL update only on a grant.

Reset
REQ-030 Reset assertion SHALL force IDLE immediately, all outputs 0, timeout counter 0, last-grant = port 1 (so port 0 wins the first tie).
REQ-031 Reset mid-transaction SHALL abandon it with no ack to any requester.

Verification
REQ-032 Single read: m0 RDEN, ADDR=0x00010, downstream returns i_RDATA=0xDEADBEEF -> o_RDEN high one cycle, o_m0_ACK at cycle +4 with o_m0_RDATA=0xDEADBEEF, ERR=0.
REQ-033 Tie: m0 write and m1 read asserted together from reset -> m0 granted first, m1 issued in the IDLE cycle after m0 ack; repeat the tie -> m1 first.
REQ-034 Timeout: m1 read, i_ACK never asserted -> o_m1_ACK=1, o_m1_ERR=1, o_m1_RDATA=0 after 15 WAIT cycles; FSM back to IDLE.
REQ-035 Illegal: m0 WREN=RDEN=1 -> o_WREN/o_RDEN stay 0, o_m0_ACK with ERR=1 one cycle after grant.
REQ-036 Reset pulse during WAIT of an m0 write -> no o_m0_ACK, o_BUSY=0, next tie grants m0.
REQ-037 Back-to-back: m0 issues 4 writes consecutively -> exactly 4 single-cycle o_WREN pulses, 4 acks, no duplicate downstream launch.

Source files
------------

// File: rtl/sram_arbiter_2p.sv
// Two-port round-robin arbiter in front of a single 32-bit SRAM controller.
// One transaction in flight; a downstream stall beyond TIMEOUT_CYC WAIT cycles returns an error.
module sram_arbiter_2p #(
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [17:0] i_m0_ADDR,
  input  logic [31:0] i_m0_WDATA,
  input  logic [3:0]  i_m0_BMASK,
  input  logic        i_m0_WREN,
  input  logic        i_m0_RDEN,
  output logic [31:0] o_m0_RDATA,
  output logic        o_m0_ACK,
  output logic        o_m0_ERR,
  input  logic [17:0] i_m1_ADDR,
  input  logic [31:0] i_m1_WDATA,
  input  logic [3:0]  i_m1_BMASK,
  input  logic        i_m1_WREN,
  input  logic        i_m1_RDEN,
  output logic [31:0] o_m1_RDATA,
  output logic        o_m1_ACK,
  output logic        o_m1_ERR,
  output logic [17:0] o_ADDR,
  output logic [31:0] o_WDATA,
  output logic [3:0]  o_BMASK,
  output logic        o_WREN,
  output logic        o_RDEN,
  input  logic [31:0] i_RDATA,
  input  logic        i_ACK,
  output logic        o_BUSY
);

  localparam int unsigned ADDR_W = 18;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = 4;
  localparam int unsigned CNT_W  = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_ERRRSP = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0]   bmask_q, bmask_d;
  logic                wr_q, wr_d;
  logic                rd_q, rd_d;
  logic                gnt_q, gnt_d;
  logic                last_q, last_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                wren_q, wren_d;
  logic                rden_q, rden_d;

  logic                pend0, pend1, sel;
  logic                ack_c, err_c;
  logic [DATA_W-1:0]   rdata_c;

  // Arbitration, request capture and transaction sequencing.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    bmask_d = bmask_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    wren_d  = 1'b0;
    rden_d  = 1'b0;

    pend0 = i_m0_WREN | i_m0_RDEN;
    pend1 = i_m1_WREN | i_m1_RDEN;
    // On a tie the port that did not win last time gets the grant.
    sel   = (pend0 & pend1) ? ~last_q : pend1;

    unique case (state_q)
      ST_IDLE: begin
        if (pend0 | pend1) begin
          gnt_d   = sel;
          last_d  = sel;
          cnt_d   = '0;
          addr_d  = sel ? i_m1_ADDR  : i_m0_ADDR;
          wdata_d = sel ? i_m1_WDATA : i_m0_WDATA;
          bmask_d = sel ? i_m1_BMASK : i_m0_BMASK;
          wr_d    = sel ? i_m1_WREN  : i_m0_WREN;
          rd_d    = sel ? i_m1_RDEN  : i_m0_RDEN;
          if (wr_d & rd_d) begin
            state_d = ST_ERRRSP;
          end else begin
            state_d = ST_ISSUE;
            wren_d  = wr_d;
            rden_d  = rd_d;
          end
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      ST_WAIT: begin
        if (i_ACK) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d = ST_ERRRSP;
        end else begin
          cnt_d = CNT_W'(cnt_q + 1'b1);
        end
      end
      ST_ERRRSP: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      bmask_q <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      wren_q  <= 1'b0;
      rden_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      bmask_q <= bmask_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      wren_q  <= wren_d;
      rden_q  <= rden_d;
    end
  end

  // Completion is combinational on i_ACK so the requester sees it in the downstream ack cycle.
  always_comb begin
    ack_c   = ((state_q == ST_WAIT) & i_ACK) | (state_q == ST_ERRRSP);
    err_c   = (state_q == ST_ERRRSP);
    rdata_c = ((state_q == ST_WAIT) & i_ACK) ? i_RDATA : '0;
  end

  assign o_m0_ACK   = ack_c & ~gnt_q;
  assign o_m0_ERR   = err_c & ~gnt_q;
  assign o_m0_RDATA = gnt_q ? '0 : rdata_c;
  assign o_m1_ACK   = ack_c & gnt_q;
  assign o_m1_ERR   = err_c & gnt_q;
  assign o_m1_RDATA = gnt_q ? rdata_c : '0;

  assign o_ADDR  = addr_q;
  assign o_WDATA = wdata_q;
  assign o_BMASK = bmask_q;
  assign o_WREN  = wren_q;
  assign o_RDEN  = rden_q;
  assign o_BUSY  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sram_arbiter_2p.sv
// Directed bench for sram_arbiter_2p with a fixed-latency downstream model
// (write ack 2 cycles, read ack 3 cycles after the launch cycle).
module tb_sram_arbiter_2p;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [17:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic [3:0]  m0_bmask, m1_bmask;
  logic        m0_wren, m0_rden, m1_wren, m1_rden;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [17:0] ds_addr;
  logic [31:0] ds_wdata, ds_rdata;
  logic [3:0]  ds_bmask;
  logic        ds_wren, ds_rden, ds_ack, busy;

  logic        ds_en = 1'b1;
  logic        ack_force = 1'b0;
  logic [1:0]  wr_pipe;
  logic [2:0]  rd_pipe;
  int          wr_pulses = 0;
  int          rd_pulses = 0;

  int n_cmp = 0;
  int n_bad = 0;

  sram_arbiter_2p #(.TIMEOUT_CYC(15)) dut (
    .i_clk(clk), .i_reset(rst_n),
    .i_m0_ADDR(m0_addr), .i_m0_WDATA(m0_wdata), .i_m0_BMASK(m0_bmask),
    .i_m0_WREN(m0_wren), .i_m0_RDEN(m0_rden),
    .o_m0_RDATA(m0_rdata), .o_m0_ACK(m0_ack), .o_m0_ERR(m0_err),
    .i_m1_ADDR(m1_addr), .i_m1_WDATA(m1_wdata), .i_m1_BMASK(m1_bmask),
    .i_m1_WREN(m1_wren), .i_m1_RDEN(m1_rden),
    .o_m1_RDATA(m1_rdata), .o_m1_ACK(m1_ack), .o_m1_ERR(m1_err),
    .o_ADDR(ds_addr), .o_WDATA(ds_wdata), .o_BMASK(ds_bmask),
    .o_WREN(ds_wren), .o_RDEN(ds_rden),
    .i_RDATA(ds_rdata), .i_ACK(ds_ack), .o_BUSY(busy)
  );

  // Downstream SRAM controller model.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_pipe <= '0;
      rd_pipe <= '0;
    end else begin
      wr_pipe   <= {wr_pipe[0], ds_wren};
      rd_pipe   <= {rd_pipe[1:0], ds_rden};
      wr_pulses <= wr_pulses + int'(ds_wren);
      rd_pulses <= rd_pulses + int'(ds_rden);
    end
  end
  assign ds_ack = ack_force | (ds_en & (wr_pipe[1] | rd_pipe[2]));

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    m0_addr = '0; m0_wdata = '0; m0_bmask = '0; m0_wren = 1'b0; m0_rden = 1'b0;
    m1_addr = '0; m1_wdata = '0; m1_bmask = '0; m1_wren = 1'b0; m1_rden = 1'b0;
  endtask

  // Steps until the given port acks; also checks the other port stays silent.
  task automatic wait_ack(input int port, input int max_cyc, output int lat,
                          output logic err, output logic [31:0] rd);
    logic a;
    lat = -1; err = 1'b0; rd = '0;
    for (int n = 1; n <= max_cyc; n++) begin
      step();
      n_cmp++;
      if (port == 0 ? (m1_ack | m1_err | (m1_rdata != 0)) : (m0_ack | m0_err | (m0_rdata != 0))) begin
        n_bad++;
        $display("FAIL idle_port_quiet: port %0d outputs active at cycle %0d", 1 - port, n);
      end
      a = (port == 0) ? m0_ack : m1_ack;
      if (a) begin
        lat = n;
        err = (port == 0) ? m0_err : m1_err;
        rd  = (port == 0) ? m0_rdata : m1_rdata;
        break;
      end
    end
    n_cmp++;
    if (lat < 0) begin
      n_bad++;
      $display("FAIL ack_timeout: port %0d no ack within %0d cycles", port, max_cyc);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    ds_rdata = '0;
    rst_n = 1'b0;
    step();
    n_cmp++;
    if ({m0_ack, m0_err, m1_ack, m1_err, ds_wren, ds_rden, busy} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b expected 0000000",
               {m0_ack, m0_err, m1_ack, m1_err, ds_wren, ds_rden, busy});
    end
    n_cmp++;
    if ({ds_addr, ds_wdata, ds_bmask, m0_rdata, m1_rdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_data: addr %h wdata %h bmask %h expected all 0", ds_addr, ds_wdata, ds_bmask);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_tie();
    int lat; logic err; logic [31:0] rd;
    ds_rdata = 32'hCAFE_F00D;
    m0_addr = 18'h00100; m0_wdata = 32'h1111_2222; m0_bmask = 4'hF; m0_wren = 1'b1;
    m1_addr = 18'h00200; m1_rden = 1'b1;
    wait_ack(0, 10, lat, err, rd);
    n_cmp++;
    if (lat !== 3 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL tie_first_m0: lat %0d err %b expected lat 3 err 0", lat, err);
    end
    m0_addr = 18'h00101;
    step();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL tie_idle_gap: busy %b expected 0", busy);
    end
    step();
    n_cmp++;
    if (ds_rden !== 1'b1 || ds_wren !== 1'b0 || ds_addr !== 18'h00200) begin
      n_bad++;
      $display("FAIL tie_second_m1: rden %b wren %b addr %h expected 1 0 00200", ds_rden, ds_wren, ds_addr);
    end
    wait_ack(1, 10, lat, err, rd);
    n_cmp++;
    if (lat !== 3 || rd !== 32'hCAFE_F00D || err !== 1'b0) begin
      n_bad++;
      $display("FAIL tie_m1_ack: lat %0d rdata %h err %b expected 3 cafef00d 0", lat, rd, err);
    end
    m1_rden = 1'b0;
    step();
    step();
    n_cmp++;
    if (ds_wren !== 1'b1 || ds_addr !== 18'h00101) begin
      n_bad++;
      $display("FAIL tie_m0_again: wren %b addr %h expected 1 00101", ds_wren, ds_addr);
    end
    wait_ack(0, 10, lat, err, rd);
    n_cmp++;
    if (lat !== 2) begin
      n_bad++;
      $display("FAIL tie_m0_again_lat: got %0d expected 2", lat);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_single_read();
    int lat; logic err; logic [31:0] rd; int rp0;
    rp0 = rd_pulses;
    ds_rdata = 32'hDEAD_BEEF;
    m0_addr = 18'h00010; m0_rden = 1'b1;
    wait_ack(0, 10, lat, err, rd);
    n_cmp++;
    if (lat !== 4 || err !== 1'b0 || rd !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL read_ack: lat %0d err %b rdata %h expected 4 0 deadbeef", lat, err, rd);
    end
    n_cmp++;
    if (ds_addr !== 18'h00010) begin
      n_bad++;
      $display("FAIL read_addr_hold: got %h expected 00010", ds_addr);
    end
    idle_inputs();
    step();
    n_cmp++;
    if (rd_pulses - rp0 !== 1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL read_launch: rden pulses %0d busy %b expected 1 0", rd_pulses - rp0, busy);
    end
  endtask

  task automatic test_timeout();
    int lat; logic err; logic [31:0] rd;
    ds_en = 1'b0;
    ds_rdata = 32'h5555_AAAA;
    m1_addr = 18'h3FFFF; m1_rden = 1'b1;
    wait_ack(1, 30, lat, err, rd);
    n_cmp++;
    if (lat !== 17 || err !== 1'b1 || rd !== 32'h0) begin
      n_bad++;
      $display("FAIL timeout_err: lat %0d err %b rdata %h expected 17 1 0", lat, err, rd);
    end
    idle_inputs();
    step();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_idle: busy %b expected 0", busy);
    end
    ds_en = 1'b1;
  endtask

  task automatic test_illegal();
    int lat; logic err; logic [31:0] rd; int wp0, rp0;
    wp0 = wr_pulses; rp0 = rd_pulses;
    m0_addr = 18'h00777; m0_wren = 1'b1; m0_rden = 1'b1;
    wait_ack(0, 5, lat, err, rd);
    n_cmp++;
    if (lat !== 1 || err !== 1'b1 || rd !== 32'h0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL illegal_err: lat %0d err %b rdata %h busy %b expected 1 1 0 1", lat, err, rd, busy);
    end
    idle_inputs();
    step();
    step();
    n_cmp++;
    if (wr_pulses != wp0 || rd_pulses != rp0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL illegal_no_launch: wren %0d rden %0d busy %b expected 0 0 0",
               wr_pulses - wp0, rd_pulses - rp0, busy);
    end
  endtask

  task automatic test_ack_ignored();
    ack_force = 1'b1;
    #1;
    n_cmp++;
    if (m0_ack !== 1'b0 || m1_ack !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL stray_ack: m0 %b m1 %b busy %b expected 0 0 0", m0_ack, m1_ack, busy);
    end
    step();
    ack_force = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL stray_ack_state: busy %b expected 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic err; logic [31:0] rd; logic seen;
    m0_addr = 18'h00050; m0_wdata = 32'h0BAD_F00D; m0_bmask = 4'h3; m0_wren = 1'b1;
    step();
    step();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || m0_ack !== 1'b0 || ds_wren !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_now: busy %b ack %b wren %b expected 0 0 0", busy, m0_ack, ds_wren);
    end
    idle_inputs();
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 0) rst_n = 1'b1;
      seen = seen | m0_ack | m1_ack;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_noack: ack seen %b expected 0", seen);
    end
    m0_addr = 18'h00060; m0_wren = 1'b1;
    m1_addr = 18'h00070; m1_wren = 1'b1;
    wait_ack(0, 10, lat, err, rd);
    n_cmp++;
    if (lat !== 3) begin
      n_bad++;
      $display("FAIL reset_mid_tie_m0: lat %0d expected 3", lat);
    end
    m0_wren = 1'b0;
    wait_ack(1, 10, lat, err, rd);
    n_cmp++;
    if (lat !== 4) begin
      n_bad++;
      $display("FAIL reset_mid_tie_m1: lat %0d expected 4", lat);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_back_to_back();
    int lat; logic err; logic [31:0] rd; int wp0, acks;
    wp0 = wr_pulses; acks = 0;
    for (int k = 0; k < 4; k++) begin
      m0_addr = 18'h00040 + 18'(k); m0_wdata = 32'hA000_0000 + 32'(k); m0_bmask = 4'hF; m0_wren = 1'b1;
      wait_ack(0, 10, lat, err, rd);
      if (lat > 0) acks++;
      n_cmp++;
      if (lat !== (k == 0 ? 3 : 4) || err !== 1'b0) begin
        n_bad++;
        $display("FAIL b2b_lat_%0d: lat %0d err %b expected %0d 0", k, lat, err, (k == 0 ? 3 : 4));
      end
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) step();
    n_cmp++;
    if (wr_pulses - wp0 !== 4 || acks !== 4) begin
      n_bad++;
      $display("FAIL b2b_count: wren pulses %0d acks %0d expected 4 4", wr_pulses - wp0, acks);
    end
  endtask

  initial begin
    test_reset();
    test_tie();
    test_single_read();
    test_timeout();
    test_illegal();
    test_ack_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
